// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared MIPS constants for the multi-cycle controller: opcodes, funct codes,
// ALU operation codes, datapath mux encodings and the sequencer state encoding.
package mips_multicycle_ctrl_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'h0;
    localparam logic [3:0] ALU_OR  = 4'h1;
    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_SUB = 4'h6;
    localparam logic [3:0] ALU_SLT = 4'h7;

    // Datapath mux encodings
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MDR = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_R_EXEC,
        S_R_WB,
        S_I_EXEC,
        S_I_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_MEM_WB,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_t;

    // States whose exit into FETCH retires an instruction
    function automatic logic is_completion(input state_t s);
        return (s == S_R_WB) || (s == S_I_WB) || (s == S_MEM_WB) ||
               (s == S_MEM_WR) || (s == S_BRANCH) || (s == S_JUMP);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// R-type funct to ALU operation decoder; flags unsupported funct codes.
module mc_alu_decoder
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       funct_valid
);

    // Pure table lookup from funct to ALU code
    always_comb begin
        alu_op      = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencer with variable-latency unified memory handshake.
// Optional performance counters enabled by defining MC_PERF_CNT_EN.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 0
`ifdef MC_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_source,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_op,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wb_sel,
    output logic        halted,
    output logic        err
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    state_t      state, state_next;
    logic        set_err;
    logic [31:0] wait_cnt;
    logic        mem_timeout;
    logic [5:0]  opcode;
    logic [3:0]  r_alu_op;
    logic        funct_valid;

    assign opcode = instr[31:26];

    mc_alu_decoder u_alu_dec (
        .funct       (instr[5:0]),
        .alu_op      (r_alu_op),
        .funct_valid (funct_valid)
    );

    // Wait counter has reached the limit and memory still has not answered
    assign mem_timeout = (MEM_TIMEOUT != 0) && !mem_ready &&
                         (wait_cnt == 32'(MEM_TIMEOUT - 1));

    // State register, sticky error flag and per-state wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            err      <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            err      <= err | set_err;
            wait_cnt <= (state_next != state) ? '0 : wait_cnt + 32'd1;
        end
    end

    // Next-state and Moore control decode
    always_comb begin
        state_next = state;
        set_err    = 1'b0;
        mem_req    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = PCSRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = '0;
        reg_write  = 1'b0;
        reg_dst    = REGDST_RT;
        wb_sel     = WB_ALU;
        halted     = 1'b0;
        case (state)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALU_ADD;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end else if (mem_timeout) begin
                    state_next = S_HALT;
                    set_err    = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                alu_op    = ALU_ADD;
                if (instr == 32'd0) begin
                    state_next = S_HALT;
                end else begin
                    case (opcode)
                        OP_RTYPE:       state_next = S_R_EXEC;
                        OP_LW, OP_SW:   state_next = S_MEM_ADDR;
                        OP_ADDI, OP_ORI: state_next = S_I_EXEC;
                        OP_BEQ, OP_BNE: state_next = S_BRANCH;
                        OP_J, OP_JAL:   state_next = S_JUMP;
                        default: begin
                            state_next = S_HALT;
                            set_err    = 1'b1;
                        end
                    endcase
                end
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_RT;
                alu_op    = r_alu_op;
                if (funct_valid) begin
                    state_next = S_R_WB;
                end else begin
                    state_next = S_HALT;
                    set_err    = 1'b1;
                end
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = REGDST_RD;
                wb_sel     = WB_ALU;
                state_next = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_op     = (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
                state_next = S_I_WB;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                reg_dst    = REGDST_RT;
                wb_sel     = WB_ALU;
                state_next = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALU_ADD;
                state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEM_WB;
                end else if (mem_timeout) begin
                    state_next = S_HALT;
                    set_err    = 1'b1;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                reg_dst    = REGDST_RT;
                wb_sel     = WB_MDR;
                state_next = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    state_next = S_FETCH;
                end else if (mem_timeout) begin
                    state_next = S_HALT;
                    set_err    = 1'b1;
                end
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_RT;
                alu_op     = ALU_SUB;
                pc_source  = PCSRC_BRANCH;
                pc_write   = zero ^ (opcode == OP_BNE);
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                if (opcode == OP_JAL) begin
                    reg_write = 1'b1;
                    reg_dst   = REGDST_RA;
                    wb_sel    = WB_PC;
                end
                state_next = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_next = S_HALT;
        endcase
    end

`ifdef MC_PERF_CNT_EN
    // Cycles spent running and instructions retired
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (state != S_HALT)
                cycle_cnt <= cycle_cnt + 1'b1;
            if (state_next == S_FETCH && is_completion(state))
                instr_cnt <= instr_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: stimulus pushes the expected
// control word per cycle, a monitor pops and compares at the falling edge.
module tb_mips_multicycle_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst_to;
    logic [31:0] instr;
    logic        zero, mem_ready, mem_ready_to;

    logic mem_req, mem_read, mem_write, iord, ir_write, pc_write;
    logic [1:0] pc_source, alu_src_b, reg_dst, wb_sel;
    logic alu_src_a, reg_write, halted, err;
    logic [3:0] alu_op;

    logic t_mem_req, t_mem_read, t_mem_write, t_iord, t_ir_write, t_pc_write;
    logic [1:0] t_pc_source, t_alu_src_b, t_reg_dst, t_wb_sel;
    logic t_alu_src_a, t_reg_write, t_halted, t_err;
    logic [3:0] t_alu_op;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt, t_cycle_cnt, t_instr_cnt;
`endif

    mips_multicycle_ctrl #(.MEM_TIMEOUT(0)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .reg_dst(reg_dst), .wb_sel(wb_sel),
        .halted(halted), .err(err)
`ifdef MC_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    mips_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst_to), .instr(instr), .zero(zero), .mem_ready(mem_ready_to),
        .mem_req(t_mem_req), .mem_read(t_mem_read), .mem_write(t_mem_write), .iord(t_iord),
        .ir_write(t_ir_write), .pc_write(t_pc_write), .pc_source(t_pc_source),
        .alu_src_a(t_alu_src_a), .alu_src_b(t_alu_src_b), .alu_op(t_alu_op),
        .reg_write(t_reg_write), .reg_dst(t_reg_dst), .wb_sel(t_wb_sel),
        .halted(t_halted), .err(t_err)
`ifdef MC_PERF_CNT_EN
        , .cycle_cnt(t_cycle_cnt), .instr_cnt(t_instr_cnt)
`endif
    );

    // Field order: req rd wr iord irw pcw pcs a b op rw rdst wb halted err
    logic [21:0] act, act_to;
    assign act = {mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_source,
                  alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, wb_sel, halted, err};
    assign act_to = {t_mem_req, t_mem_read, t_mem_write, t_iord, t_ir_write, t_pc_write,
                     t_pc_source, t_alu_src_a, t_alu_src_b, t_alu_op, t_reg_write,
                     t_reg_dst, t_wb_sel, t_halted, t_err};

    function automatic logic [21:0] mk(
        input logic req, rd, wr, io, irw, pcw, input logic [1:0] pcs,
        input logic a, input logic [1:0] b, input logic [3:0] op,
        input logic rw, input logic [1:0] rdst, wb, input logic h, er);
        return {req, rd, wr, io, irw, pcw, pcs, a, b, op, rw, rdst, wb, h, er};
    endfunction

    // ALU codes: AND=0 OR=1 ADD=2 SUB=6 SLT=7
    localparam logic [21:0] E_IDLE  = 22'd0;
    localparam logic [21:0] E_FW    = mk(1,1,0,0, 0,0,2'b00, 0,2'b01, 4'h2, 0,2'b00,2'b00, 0,0);
    localparam logic [21:0] E_FR    = mk(1,1,0,0, 1,1,2'b00, 0,2'b01, 4'h2, 0,2'b00,2'b00, 0,0);
    localparam logic [21:0] E_DEC   = mk(0,0,0,0, 0,0,2'b00, 0,2'b11, 4'h2, 0,2'b00,2'b00, 0,0);
    localparam logic [21:0] E_RADD  = mk(0,0,0,0, 0,0,2'b00, 1,2'b00, 4'h2, 0,2'b00,2'b00, 0,0);
    localparam logic [21:0] E_RSLT  = mk(0,0,0,0, 0,0,2'b00, 1,2'b00, 4'h7, 0,2'b00,2'b00, 0,0);
    localparam logic [21:0] E_RWB   = mk(0,0,0,0, 0,0,2'b00, 0,2'b00, 4'h0, 1,2'b01,2'b00, 0,0);
    localparam logic [21:0] E_IADD  = mk(0,0,0,0, 0,0,2'b00, 1,2'b10, 4'h2, 0,2'b00,2'b00, 0,0);
    localparam logic [21:0] E_IOR   = mk(0,0,0,0, 0,0,2'b00, 1,2'b10, 4'h1, 0,2'b00,2'b00, 0,0);
    localparam logic [21:0] E_IWB   = mk(0,0,0,0, 0,0,2'b00, 0,2'b00, 4'h0, 1,2'b00,2'b00, 0,0);
    localparam logic [21:0] E_MADDR = mk(0,0,0,0, 0,0,2'b00, 1,2'b10, 4'h2, 0,2'b00,2'b00, 0,0);
    localparam logic [21:0] E_MRD   = mk(1,1,0,1, 0,0,2'b00, 0,2'b00, 4'h0, 0,2'b00,2'b00, 0,0);
    localparam logic [21:0] E_MWB   = mk(0,0,0,0, 0,0,2'b00, 0,2'b00, 4'h0, 1,2'b00,2'b01, 0,0);
    localparam logic [21:0] E_MWR   = mk(1,0,1,1, 0,0,2'b00, 0,2'b00, 4'h0, 0,2'b00,2'b00, 0,0);
    localparam logic [21:0] E_BRT   = mk(0,0,0,0, 0,1,2'b01, 1,2'b00, 4'h6, 0,2'b00,2'b00, 0,0);
    localparam logic [21:0] E_BRN   = mk(0,0,0,0, 0,0,2'b01, 1,2'b00, 4'h6, 0,2'b00,2'b00, 0,0);
    localparam logic [21:0] E_JAL   = mk(0,0,0,0, 0,1,2'b10, 0,2'b00, 4'h0, 1,2'b10,2'b10, 0,0);
    localparam logic [21:0] E_J     = mk(0,0,0,0, 0,1,2'b10, 0,2'b00, 4'h0, 0,2'b00,2'b00, 0,0);
    localparam logic [21:0] E_HLT   = mk(0,0,0,0, 0,0,2'b00, 0,2'b00, 4'h0, 0,2'b00,2'b00, 1,0);
    localparam logic [21:0] E_HERR  = mk(0,0,0,0, 0,0,2'b00, 0,2'b00, 4'h0, 0,2'b00,2'b00, 1,1);

    typedef struct {
        string       nm;
        bit          to;
        logic [21:0] e;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    event chk_ev;

    // Monitor: compare one expected word per falling edge or explicit sample
    always begin
        exp_t x;
        logic [21:0] a;
        @(negedge clk or chk_ev);
        if (q.size() > 0) begin
            x = q.pop_front();
            a = x.to ? act_to : act;
            n_total++;
            if (a === x.e) n_pass++;
            else $display("FAIL %s: got %h expected %h", x.nm, a, x.e);
        end
    end

    task automatic cyc(input logic [21:0] e, input string nm, input bit to = 1'b0);
        exp_t x;
        x.nm = nm; x.to = to; x.e = e;
        q.push_back(x);
        @(posedge clk); #1;
    endtask

    task automatic skip_cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(E_IDLE, "rst_hold");
        rst = 1'b0;
        cyc(E_IDLE, "idle");
    endtask

    task automatic fetch_decode(input logic [31:0] ins, input string nm);
        instr = ins;
        mem_ready = 1'b1;
        cyc(E_FR, {nm, "_fetch"});
        cyc(E_DEC, {nm, "_decode"});
    endtask

    initial begin
        exp_t x;
        rst = 1'b1; rst_to = 1'b1;
        instr = '0; zero = 1'b0; mem_ready = 1'b0; mem_ready_to = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc(E_IDLE, "reset_state");
        rst = 1'b0;
        cyc(E_IDLE, "idle_after_release");
        cyc(E_FW, "fetch_wait");
        // Asynchronous reset mid-fetch: mem_req must drop before any edge
        #2 rst = 1'b1;
        #1;
        x.nm = "rst_async_drop"; x.to = 1'b0; x.e = E_IDLE;
        q.push_back(x);
        -> chk_ev;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(E_IDLE, "idle_after_async_rst");

        fetch_decode(32'h012A4020, "add");
        cyc(E_RADD, "add_exec");
        cyc(E_RWB, "add_wb");

        fetch_decode(32'h012A402A, "slt");
        cyc(E_RSLT, "slt_exec");
        cyc(E_RWB, "slt_wb");

        fetch_decode(32'h8D090004, "lw");
        cyc(E_MADDR, "lw_addr");
        mem_ready = 1'b0;
        repeat (3) cyc(E_MRD, "lw_rd_wait");
        mem_ready = 1'b1;
        cyc(E_MRD, "lw_rd_done");
        cyc(E_MWB, "lw_wb");

        fetch_decode(32'hAD090004, "sw");
        cyc(E_MADDR, "sw_addr");
        cyc(E_MWR, "sw_wr");

        fetch_decode(32'h21090005, "addi");
        cyc(E_IADD, "addi_exec");
        cyc(E_IWB, "addi_wb");

        fetch_decode(32'h35090001, "ori");
        cyc(E_IOR, "ori_exec");
        cyc(E_IWB, "ori_wb");

        fetch_decode(32'h15090003, "bne");
        zero = 1'b0;
        cyc(E_BRT, "bne_z0_taken");
        fetch_decode(32'h11090003, "beq");
        cyc(E_BRN, "beq_z0_not_taken");
        fetch_decode(32'h11090003, "beq1");
        zero = 1'b1;
        cyc(E_BRT, "beq_z1_taken");
        zero = 1'b0;

        fetch_decode(32'h0C100000, "jal");
        cyc(E_JAL, "jal_jump");
        fetch_decode(32'h08100000, "j");
        cyc(E_J, "j_jump");

        fetch_decode(32'h00000000, "nop0");
        cyc(E_HLT, "halt_zero");
        cyc(E_HLT, "halt_zero_hold");

        do_reset();
        fetch_decode(32'hFC000000, "badop");
        cyc(E_HERR, "halt_badop");
        cyc(E_HERR, "halt_badop_hold");

        do_reset();
        fetch_decode(32'h012A4021, "badfn");
        skip_cyc();
        cyc(E_HERR, "halt_badfunct");

        // Timeout instance: memory never answers in FETCH
        rst_to = 1'b0;
        cyc(E_IDLE, "to_idle", 1'b1);
        repeat (4) cyc(E_FW, "to_fetch_wait", 1'b1);
        cyc(E_HERR, "to_halt", 1'b1);
        cyc(E_HERR, "to_halt_hold", 1'b1);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
